// File: rtl/reg_writeback_ctrl.sv
// Register file write-side controller: per-register pending scoreboard, a result queue drained
// one entry per cycle onto the write port, and decode forwarding/stall for two read operands.
module reg_writeback_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_wr,
  input  logic [2:0]        issue_dest,
  output logic              issue_ready,
  input  logic              res_valid,
  input  logic [2:0]        res_dest,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  input  logic              wb_hold,
  output logic [2:0]        write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              reg_write,
  input  logic [2:0]        read_addr1,
  input  logic [2:0]        read_addr2,
  output logic              fwd_hit1,
  output logic [DATA_W-1:0] fwd_data1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data2,
  output logic              stall,
  output logic              err
);

  localparam int unsigned PtrW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned NumRegs = 8;
  localparam int unsigned CmpW    = (CNT_W > PtrW + 1) ? CNT_W : PtrW + 1;
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [PtrW:0]    QFull  = (PtrW + 1)'(QDEPTH);

  logic [2:0]        q_dest_q [QDEPTH];
  logic [2:0]        q_dest_d [QDEPTH];
  logic [DATA_W-1:0] q_data_q [QDEPTH];
  logic [DATA_W-1:0] q_data_d [QDEPTH];
  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PtrW:0]     count_q, count_d;
  logic [CNT_W-1:0]  pend_q [NumRegs];
  logic [CNT_W-1:0]  pend_d [NumRegs];
  logic              err_q, err_d;

  logic empty, full, push, pop, issue_fire;

  logic [2:0]        rd_addr [2];
  logic              hit     [2];
  logic [DATA_W-1:0] fdata   [2];
  logic [PtrW:0]     qcnt    [2];
  logic [PtrW-1:0]   idx;

  assign empty       = (count_q == '0);
  assign full        = (count_q == QFull);
  assign res_ready   = !full;
  assign reg_write   = !empty && !wb_hold;
  assign issue_ready = (pend_q[issue_dest] != CntMax);
  assign write_addr  = empty ? 3'd0 : q_dest_q[head_q];
  assign write_data  = empty ? '0 : q_data_q[head_q];
  assign push        = res_valid && res_ready;
  assign pop         = reg_write;
  assign issue_fire  = issue_valid && issue_ready && issue_wr;
  assign err         = err_q;

  assign rd_addr[0] = read_addr1;
  assign rd_addr[1] = read_addr2;
  assign fwd_hit1   = hit[0];
  assign fwd_data1  = fdata[0];
  assign fwd_hit2   = hit[1];
  assign fwd_data2  = fdata[1];

  // Walk oldest to newest so the last match left standing is the newest queued result.
  always_comb begin
    idx = '0;
    for (int p = 0; p < 2; p++) begin
      hit[p]   = 1'b0;
      fdata[p] = '0;
      qcnt[p]  = '0;
    end
    for (int i = 0; i < QDEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if ((PtrW + 1)'(i) < count_q) begin
        for (int p = 0; p < 2; p++) begin
          if (q_dest_q[idx] == rd_addr[p]) begin
            hit[p]   = 1'b1;
            fdata[p] = q_data_q[idx];
            qcnt[p]  = qcnt[p] + (PtrW + 1)'(1);
          end
        end
      end
    end
  end

  // Stall whenever more writes are outstanding than results already queued for that register.
  assign stall = (CmpW'(pend_q[read_addr1]) > CmpW'(qcnt[0])) ||
                 (CmpW'(pend_q[read_addr2]) > CmpW'(qcnt[1]));

  always_comb begin
    q_dest_d = q_dest_q;
    q_data_d = q_data_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    err_d    = err_q;
    pend_d   = pend_q;

    if (push) begin
      q_dest_d[tail_q] = res_dest;
      q_data_d[tail_q] = res_data;
      tail_d           = tail_q + PtrW'(1);
      if (pend_q[res_dest] == '0) err_d = 1'b1;
    end
    if (pop) head_d = head_q + PtrW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase

    // A pop against a zero counter (orphan result) leaves it at zero.
    for (int r = 0; r < NumRegs; r++) begin
      logic inc, dec;
      inc = issue_fire && (issue_dest == 3'(r));
      dec = pop && (write_addr == 3'(r)) && (pend_q[r] != '0);
      if (inc && !dec)      pend_d[r] = pend_q[r] + CNT_W'(1);
      else if (dec && !inc) pend_d[r] = pend_q[r] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_dest_q[i] <= '0;
        q_data_q[i] <= '0;
      end
      for (int r = 0; r < NumRegs; r++) pend_q[r] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      q_dest_q <= q_dest_d;
      q_data_q <= q_data_d;
      pend_q   <= pend_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed-vector bench for reg_writeback_ctrl: one table row per clock cycle, plus a
// hand-written mid-queue reset sequence.
module tb_reg_writeback_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_wr, res_valid, wb_hold;
  logic [2:0]  issue_dest, res_dest, read_addr1, read_addr2;
  logic [15:0] res_data;
  logic        issue_ready, res_ready, reg_write, fwd_hit1, fwd_hit2, stall, err;
  logic [2:0]  write_addr;
  logic [15:0] write_data, fwd_data1, fwd_data2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_writeback_ctrl #(.DATA_W(16), .QDEPTH(4), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_dest(issue_dest),
    .issue_ready(issue_ready),
    .res_valid(res_valid), .res_dest(res_dest), .res_data(res_data), .res_ready(res_ready),
    .wb_hold(wb_hold),
    .write_addr(write_addr), .write_data(write_data), .reg_write(reg_write),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .stall(stall), .err(err)
  );

  typedef struct {
    logic        iv, iwr; logic [2:0] id;
    logic        rv; logic [2:0] rd; logic [15:0] rdata;
    logic        hold; logic [2:0] ra1, ra2;
    logic        ir, rr, rw; logic [2:0] wa; logic [15:0] wd;
    logic        h1; logic [15:0] d1; logic h2; logic [15:0] d2;
    logic        st, er;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic iv, input logic iwr, input logic [2:0] id,
    input logic rv, input logic [2:0] rd, input logic [15:0] rdata,
    input logic hold, input logic [2:0] ra1, input logic [2:0] ra2,
    input logic ir, input logic rr, input logic rw, input logic [2:0] wa, input logic [15:0] wd,
    input logic h1, input logic [15:0] d1, input logic h2, input logic [15:0] d2,
    input logic st, input logic er);
    vec_t v;
    v.iv = iv; v.iwr = iwr; v.id = id; v.rv = rv; v.rd = rd; v.rdata = rdata;
    v.hold = hold; v.ra1 = ra1; v.ra2 = ra2;
    v.ir = ir; v.rr = rr; v.rw = rw; v.wa = wa; v.wd = wd;
    v.h1 = h1; v.d1 = d1; v.h2 = h2; v.d2 = d2; v.st = st; v.er = er;
    return v;
  endfunction

  function automatic logic [57:0] pack_exp(input vec_t v);
    return {v.ir, v.rr, v.rw, v.wa, v.wd, v.h1, v.d1, v.h2, v.d2, v.st, v.er};
  endfunction

  function automatic logic [57:0] pack_act();
    return {issue_ready, res_ready, reg_write, write_addr, write_data,
            fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, stall, err};
  endfunction

  task automatic drive(input vec_t v);
    issue_valid = v.iv; issue_wr = v.iwr; issue_dest = v.id;
    res_valid = v.rv; res_dest = v.rd; res_data = v.rdata;
    wb_hold = v.hold; read_addr1 = v.ra1; read_addr2 = v.ra2;
  endtask

  task automatic check(input string name, input logic [57:0] act, input logic [57:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got={ir,rr,rw,wa,wd,h1,d1,h2,d2,st,err}=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b required=%b", name, act, exp);
    end
  endtask

  vec_t idle_v;

  initial begin
    // Basic write, forwarding and stall on r3.
    vecs.push_back(mk(0,0,0, 0,0,0, 0, 0,0, 1,1,0,0,0, 0,0,0,0, 0,0));
    vecs.push_back(mk(1,1,3, 0,0,0, 0, 3,0, 1,1,0,0,0, 0,0,0,0, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0, 3,0, 1,1,0,0,0, 0,0,0,0, 1,0));
    vecs.push_back(mk(0,0,0, 1,3,16'h00AB, 0, 3,0, 1,1,0,0,0, 0,0,0,0, 1,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0, 3,0, 1,1,1,3,16'h00AB, 1,16'h00AB,0,0, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0, 3,0, 1,1,0,0,0, 0,0,0,0, 0,0));
    // Fill the queue under hold, then drain four in a row.
    for (int k = 1; k <= 4; k++)
      vecs.push_back(mk(1,1,3'(k), 0,0,0, 1, 0,0, 1,1,0,0,0, 0,0,0,0, 0,0));
    vecs.push_back(mk(0,0,0, 1,1,16'h0101, 1, 0,0, 1,1,0,0,0, 0,0,0,0, 0,0));
    vecs.push_back(mk(0,0,0, 1,2,16'h0202, 1, 0,0, 1,1,0,1,16'h0101, 0,0,0,0, 0,0));
    vecs.push_back(mk(0,0,0, 1,3,16'h0303, 1, 0,0, 1,1,0,1,16'h0101, 0,0,0,0, 0,0));
    vecs.push_back(mk(0,0,0, 1,4,16'h0404, 1, 0,0, 1,1,0,1,16'h0101, 0,0,0,0, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1, 4,1, 1,0,0,1,16'h0101, 1,16'h0404,1,16'h0101, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0, 0,0, 1,0,1,1,16'h0101, 0,0,0,0, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0, 0,0, 1,1,1,2,16'h0202, 0,0,0,0, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0, 0,0, 1,1,1,3,16'h0303, 0,0,0,0, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0, 0,0, 1,1,1,4,16'h0404, 0,0,0,0, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0, 0,0, 1,1,0,0,0, 0,0,0,0, 0,0));
    // Two writes to r5: newest forwards, stale hit still stalls.
    vecs.push_back(mk(1,1,5, 0,0,0, 1, 0,0, 1,1,0,0,0, 0,0,0,0, 0,0));
    vecs.push_back(mk(1,1,5, 0,0,0, 1, 0,0, 1,1,0,0,0, 0,0,0,0, 0,0));
    vecs.push_back(mk(0,0,0, 1,5,16'h1111, 1, 5,0, 1,1,0,0,0, 0,0,0,0, 1,0));
    vecs.push_back(mk(0,0,0, 1,5,16'h2222, 1, 5,0, 1,1,0,5,16'h1111, 1,16'h1111,0,0, 1,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1, 5,0, 1,1,0,5,16'h1111, 1,16'h2222,0,0, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0, 5,0, 1,1,1,5,16'h1111, 1,16'h2222,0,0, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0, 5,0, 1,1,1,5,16'h2222, 1,16'h2222,0,0, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0, 5,0, 1,1,0,0,0, 0,0,0,0, 0,0));
    // Saturate r2, then issue+pop on r2 at count 2 must hold the count.
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1,1,2, 0,0,0, 0, 0,0, 1,1,0,0,0, 0,0,0,0, 0,0));
    vecs.push_back(mk(1,1,2, 0,0,0, 0, 0,2, 0,1,0,0,0, 0,0,0,0, 1,0));
    vecs.push_back(mk(0,0,0, 1,2,16'h0A0A, 1, 0,0, 1,1,0,0,0, 0,0,0,0, 0,0));
    vecs.push_back(mk(0,0,0, 1,2,16'h0B0B, 1, 0,0, 1,1,0,2,16'h0A0A, 0,0,0,0, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0, 0,0, 1,1,1,2,16'h0A0A, 0,0,0,0, 0,0));
    vecs.push_back(mk(1,1,2, 0,0,0, 0, 0,0, 1,1,1,2,16'h0B0B, 0,0,0,0, 0,0));
    vecs.push_back(mk(0,0,2, 0,0,0, 0, 0,2, 1,1,0,0,0, 0,0,0,0, 1,0));
    vecs.push_back(mk(1,1,2, 0,0,0, 0, 0,0, 1,1,0,0,0, 0,0,0,0, 0,0));
    vecs.push_back(mk(1,1,2, 0,0,0, 0, 0,0, 0,1,0,0,0, 0,0,0,0, 0,0));
    // At max, an issue is blocked even while an r2 pop happens.
    vecs.push_back(mk(0,0,0, 1,2,16'h0C0C, 1, 0,0, 1,1,0,0,0, 0,0,0,0, 0,0));
    vecs.push_back(mk(1,1,2, 0,0,0, 0, 0,0, 0,1,1,2,16'h0C0C, 0,0,0,0, 0,0));
    vecs.push_back(mk(0,0,2, 0,0,0, 0, 0,0, 1,1,0,0,0, 0,0,0,0, 0,0));
    // Orphan result on r6: sticky err, counter must not wrap.
    vecs.push_back(mk(0,0,0, 1,6,16'h0066, 0, 0,0, 1,1,0,0,0, 0,0,0,0, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0, 0,0, 1,1,1,6,16'h0066, 0,0,0,0, 0,1));
    vecs.push_back(mk(0,0,0, 0,0,0, 0, 6,0, 1,1,0,0,0, 0,0,0,0, 0,1));
    vecs.push_back(mk(0,0,6, 0,0,0, 0, 0,0, 1,1,0,0,0, 0,0,0,0, 0,1));

    idle_v = mk(0,0,0, 0,0,0, 0, 0,0, 1,1,0,0,0, 0,0,0,0, 0,0);
    drive(idle_v);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", pack_act(), pack_exp(idle_v));
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      check($sformatf("vec%0d", i), pack_act(), pack_exp(vecs[i]));
    end

    // Queue three results under hold, then reset mid-queue.
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      drive(idle_v);
      wb_hold = 1'b1; res_valid = 1'b1; res_dest = 3'(k); res_data = 16'(16'h0E00 + k);
    end
    @(negedge clk);
    drive(idle_v);
    wb_hold = 1'b1;
    #1;
    check1("midq_nonempty_before_reset", write_addr == 3'd1, 1'b1);
    wb_hold = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check1("midq_reset_reg_write", reg_write, 1'b0);
    check1("midq_reset_err_cleared", err, 1'b0);
    check1("midq_reset_res_ready", res_ready, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    read_addr2 = 3'd2;
    @(negedge clk);
    #2;
    check1("after_reset_reg_write", reg_write, 1'b0);
    check1("after_reset_write_addr_zero", write_addr == 3'd0, 1'b1);
    check1("after_reset_pend2_cleared", stall, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
